// File: rtl/rf_cmd_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rf_cmd_sequencer_if
// Purpose  : Command/response handshake bundle between the control unit
//            (master) and the register-file command sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface rf_cmd_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_dst;
  logic [2:0]        cmd_src;
  logic [DATA_W-1:0] cmd_imm;
  logic [CNT_W-1:0]  cmd_cnt;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, cmd_cnt,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, cmd_cnt,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/rf_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rf_cmd_sequencer
// Purpose  : Expands one command at a time into register-file micro-ops
//            (clear, load-immediate, repeated inc/dec, read, move, swap) and
//            returns a single-cycle completion response per command.
// Revision : 1.0 - initial release
// ============================================================================
module rf_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  wire                    clk,
  input  wire                    rst_n,
  rf_cmd_sequencer_if.slave      cmd_if,
  output logic [1:0]             rf_FunSel,
  output logic [3:0]             rf_RSel,
  output logic [3:0]             rf_TSel,
  output logic [2:0]             rf_O1Sel,
  output logic [2:0]             rf_O2Sel,
  output logic [DATA_W-1:0]      rf_I,
  input  wire  [DATA_W-1:0]      rf_O1,
  input  wire  [DATA_W-1:0]      rf_O2
);

  localparam logic [2:0] c_OP_NOP  = 3'b000;
  localparam logic [2:0] c_OP_CLR  = 3'b001;
  localparam logic [2:0] c_OP_LDI  = 3'b010;
  localparam logic [2:0] c_OP_INC  = 3'b011;
  localparam logic [2:0] c_OP_DEC  = 3'b100;
  localparam logic [2:0] c_OP_MOV  = 3'b101;
  localparam logic [2:0] c_OP_RD   = 3'b110;
  localparam logic [2:0] c_OP_SWAP = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    REP  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [2:0]        r_dst;
  logic [2:0]        r_src;
  logic [DATA_W-1:0] r_imm;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_data;
  logic [2:0]        r_o1sel;
  logic [2:0]        r_o2sel;
  logic              w_accept;
  logic              w_wr;
  logic [2:0]        w_wr_idx;

  // First state of each command; shared by the IDLE and RESP accept paths.
  function automatic state_t f_dispatch(input logic [2:0] op);
    case (op)
      c_OP_NOP:           f_dispatch = RESP;
      c_OP_CLR, c_OP_LDI: f_dispatch = WR1;
      c_OP_INC, c_OP_DEC: f_dispatch = REP;
      default:            f_dispatch = CAPT;
    endcase
  endfunction

  // RESP also accepts so the next command starts back-to-back.
  assign cmd_if.cmd_ready = (r_state == IDLE) || (r_state == RESP);
  assign cmd_if.rsp_valid = (r_state == RESP);
  assign cmd_if.rsp_data  = r_rsp_data;
  assign w_accept         = cmd_if.cmd_valid & cmd_if.cmd_ready;
  assign rf_O1Sel         = r_o1sel;
  assign rf_O2Sel         = r_o2sel;

  // State register; reset aborts any command in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state sequencing of the micro-op steps.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = f_dispatch(cmd_if.cmd_op);
      CAPT: begin
        if (r_op == c_OP_RD || (r_op == c_OP_SWAP && r_dst == r_src)) w_next = RESP;
        else                                                          w_next = WR1;
      end
      WR1:  w_next = (r_op == c_OP_SWAP) ? WR2 : RESP;
      WR2:  w_next = RESP;
      REP:  if (r_cnt <= CNT_W'(1)) w_next = RESP;
      RESP: w_next = w_accept ? f_dispatch(cmd_if.cmd_op) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command latch, repeat counter and operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_dst      <= '0;
      r_src      <= '0;
      r_imm      <= '0;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
      r_o1sel    <= '0;
      r_o2sel    <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_if.cmd_op;
        r_dst      <= cmd_if.cmd_dst;
        r_src      <= cmd_if.cmd_src;
        r_imm      <= cmd_if.cmd_imm;
        r_cnt      <= cmd_if.cmd_cnt;
        r_rsp_data <= (cmd_if.cmd_op == c_OP_LDI) ? cmd_if.cmd_imm : '0;
        // Read selects are set up at accept so they are stable throughout CAPT.
        if (cmd_if.cmd_op == c_OP_SWAP) begin
          r_o1sel <= cmd_if.cmd_dst;
          r_o2sel <= cmd_if.cmd_src;
        end else if (cmd_if.cmd_op == c_OP_RD || cmd_if.cmd_op == c_OP_MOV) begin
          r_o1sel <= cmd_if.cmd_src;
        end
      end else if (r_state == REP && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == CAPT) begin
        r_a        <= rf_O1;
        r_b        <= rf_O2;
        r_rsp_data <= rf_O1;
      end
    end
  end

  // RF function, load data and write target for the current micro-op.
  always_comb begin
    rf_FunSel = 2'b01;
    rf_I      = '0;
    w_wr      = 1'b0;
    w_wr_idx  = r_dst;
    case (r_state)
      WR1: begin
        w_wr = 1'b1;
        if (r_op == c_OP_CLR)       rf_FunSel = 2'b00;
        if (r_op == c_OP_LDI)       rf_I = r_imm;
        else if (r_op == c_OP_SWAP) rf_I = r_b;
        else                        rf_I = r_a;
      end
      WR2: begin
        w_wr     = 1'b1;
        w_wr_idx = r_src;
        rf_I     = r_a;
      end
      REP: begin
        // A zero count still spends one REP cycle but never writes.
        w_wr      = (r_cnt != '0);
        rf_FunSel = (r_op == c_OP_INC) ? 2'b11 : 2'b10;
      end
      default: ;
    endcase
  end

  // One-hot enable decode; bit (3-idx[1:0]) equals ~idx[1:0] for 2-bit values.
  always_comb begin
    rf_RSel = '0;
    rf_TSel = '0;
    if (w_wr) begin
      if (w_wr_idx[2]) rf_RSel[~w_wr_idx[1:0]] = 1'b1;
      else             rf_TSel[~w_wr_idx[1:0]] = 1'b1;
    end
  end

endmodule
`default_nettype wire
